motion_frame_ctrl: RTL and testbench

Frame-level controller for the motion-detection pipeline (grey conversion -> frame difference -> erosion -> dilation). It latches host configuration into shadow registers only at input frame start, so a frame is never processed with mixed settings, and toggles the reference-buffer select each frame. It also tracks each frame from pipeline entry to pipeline exit, checks input geometry, and counts motion pixels on the dilation output to raise a per-frame alarm.

---
 rtl/motion_frame_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_motion_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_frame_ctrl.sv
// Frame-level controller for the motion-detection pipeline: shadows host config at
// input frame start, ping-pongs the reference buffer and reports per-frame results.
module motion_frame_ctrl #(
    parameter int          IMG_HDISP    = 640,
    parameter int          IMG_VDISP    = 480,
    parameter logic [7:0]  DIFF_THR_DEF = 8'd80,
    parameter logic [18:0] ALARM_DEF    = 19'd1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_enable,
    input  logic        cfg_wr_en,
    input  logic [7:0]  cfg_threshold,
    input  logic [18:0] cfg_alarm_level,
    input  logic        cfg_bypass_erode,
    input  logic        cfg_bypass_dilate,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        post_frame_vsync,
    input  logic        post_frame_href,
    input  logic        post_frame_clken,
    input  logic        post_img_Bit,
    output logic [7:0]  diff_threshold,
    output logic        erode_bypass,
    output logic        dilate_bypass,
    output logic        ref_sel,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [18:0] motion_cnt,
    output logic        motion_alarm,
    output logic        frame_err,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, WAIT_VS, ACTIVE, DRAIN, REPORT} state_t;

    localparam logic [10:0] CNT_MAX = '1;
    localparam logic [18:0] MOT_MAX = '1;
    localparam logic [10:0] HDISP_C = 11'(IMG_HDISP);
    localparam logic [10:0] VDISP_C = 11'(IMG_VDISP);

    state_t state_q, state_d;

    logic inVsD1_q, outVsD1_q, inHrefD1_q;
    logic inRise, inFall, outFall, hrefFall;
    logic loadCfg, geomEn, motionEn, latchGeom, reportEn, overrunSet;

    logic [7:0]  pendThr_q, pendThr_d, actThr_q, actThr_d;
    logic [18:0] pendAlarm_q, pendAlarm_d, actAlarm_q, actAlarm_d;
    logic        pendBypE_q, pendBypE_d, pendBypD_q, pendBypD_d;
    logic        actBypE_q, actBypE_d, actBypD_q, actBypD_d;
    logic [10:0] pixCnt_q, pixCnt_d, lineCnt_q, lineCnt_d;
    logic        lineErr_q, lineErr_d, geomErr_q, geomErr_d;
    logic [18:0] motionAcc_q, motionAcc_d, motionCnt_q, motionCnt_d;
    logic        busy_q, busy_d, frameDone_q, frameDone_d;
    logic        alarm_q, alarm_d, frameErr_q, frameErr_d;
    logic        overrun_q, overrun_d, refSel_q, refSel_d;
    logic [15:0] frameCnt_q, frameCnt_d;

    assign inRise   = per_frame_vsync & ~inVsD1_q;
    assign inFall   = ~per_frame_vsync & inVsD1_q;
    assign outFall  = ~post_frame_vsync & outVsD1_q;
    assign hrefFall = ~per_frame_href & inHrefD1_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_enable) state_d = WAIT_VS;
            WAIT_VS: begin
                if (!cfg_enable)  state_d = IDLE;
                else if (inRise)  state_d = ACTIVE;
            end
            ACTIVE:  if (inFall)  state_d = DRAIN;
            DRAIN:   if (outFall) state_d = REPORT;
            REPORT:  state_d = cfg_enable ? WAIT_VS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        loadCfg    = (state_q == WAIT_VS) && cfg_enable && inRise;
        geomEn     = (state_q == ACTIVE);
        motionEn   = (state_q == ACTIVE) || (state_q == DRAIN);
        latchGeom  = (state_q == ACTIVE) && inFall;
        reportEn   = (state_q == REPORT);
        overrunSet = (state_q == DRAIN) && inRise;
    end

    // The active set is taken from the pending _d values so a write in the very
    // cycle of the frame-start edge already applies to that frame.
    always_comb begin
        pendThr_d   = pendThr_q;
        pendAlarm_d = pendAlarm_q;
        pendBypE_d  = pendBypE_q;
        pendBypD_d  = pendBypD_q;
        actThr_d    = actThr_q;
        actAlarm_d  = actAlarm_q;
        actBypE_d   = actBypE_q;
        actBypD_d   = actBypD_q;
        pixCnt_d    = pixCnt_q;
        lineCnt_d   = lineCnt_q;
        lineErr_d   = lineErr_q;
        geomErr_d   = geomErr_q;
        motionAcc_d = motionAcc_q;
        motionCnt_d = motionCnt_q;
        alarm_d     = alarm_q;
        frameErr_d  = frameErr_q;
        frameCnt_d  = frameCnt_q;
        refSel_d    = refSel_q;
        overrun_d   = overrun_q;
        frameDone_d = 1'b0;
        busy_d      = (state_q == ACTIVE) || (state_q == DRAIN);

        if (cfg_wr_en) begin
            pendThr_d   = cfg_threshold;
            pendAlarm_d = cfg_alarm_level;
            pendBypE_d  = cfg_bypass_erode;
            pendBypD_d  = cfg_bypass_dilate;
            overrun_d   = 1'b0;
        end
        if (overrunSet) overrun_d = 1'b1;

        if (loadCfg) begin
            actThr_d    = pendThr_d;
            actAlarm_d  = pendAlarm_d;
            actBypE_d   = pendBypE_d;
            actBypD_d   = pendBypD_d;
            pixCnt_d    = '0;
            lineCnt_d   = '0;
            lineErr_d   = 1'b0;
            geomErr_d   = 1'b0;
            motionAcc_d = '0;
        end

        if (geomEn) begin
            if (hrefFall) begin
                pixCnt_d = '0;
                if (pixCnt_q != HDISP_C) lineErr_d = 1'b1;
                if (lineCnt_q != CNT_MAX) lineCnt_d = lineCnt_q + 11'd1;
            end else if (per_frame_href && per_frame_clken && (pixCnt_q != CNT_MAX)) begin
                pixCnt_d = pixCnt_q + 11'd1;
            end
        end
        if (latchGeom) geomErr_d = lineErr_d || (lineCnt_d != VDISP_C);

        if (motionEn && post_frame_href && post_frame_clken && post_img_Bit
            && (motionAcc_q != MOT_MAX)) begin
            motionAcc_d = motionAcc_q + 19'd1;
        end

        if (reportEn) begin
            frameDone_d = 1'b1;
            motionCnt_d = motionAcc_q;
            alarm_d     = (motionAcc_q >= actAlarm_q);
            frameErr_d  = geomErr_q;
            frameCnt_d  = frameCnt_q + 16'd1;
            refSel_d    = ~refSel_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            inVsD1_q    <= 1'b0;
            outVsD1_q   <= 1'b0;
            inHrefD1_q  <= 1'b0;
            pendThr_q   <= DIFF_THR_DEF;
            pendAlarm_q <= ALARM_DEF;
            pendBypE_q  <= 1'b0;
            pendBypD_q  <= 1'b0;
            actThr_q    <= DIFF_THR_DEF;
            actAlarm_q  <= ALARM_DEF;
            actBypE_q   <= 1'b0;
            actBypD_q   <= 1'b0;
            pixCnt_q    <= '0;
            lineCnt_q   <= '0;
            lineErr_q   <= 1'b0;
            geomErr_q   <= 1'b0;
            motionAcc_q <= '0;
            motionCnt_q <= '0;
            alarm_q     <= 1'b0;
            frameErr_q  <= 1'b0;
            frameCnt_q  <= '0;
            refSel_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            inVsD1_q    <= per_frame_vsync;
            outVsD1_q   <= post_frame_vsync;
            inHrefD1_q  <= per_frame_href;
            pendThr_q   <= pendThr_d;
            pendAlarm_q <= pendAlarm_d;
            pendBypE_q  <= pendBypE_d;
            pendBypD_q  <= pendBypD_d;
            actThr_q    <= actThr_d;
            actAlarm_q  <= actAlarm_d;
            actBypE_q   <= actBypE_d;
            actBypD_q   <= actBypD_d;
            pixCnt_q    <= pixCnt_d;
            lineCnt_q   <= lineCnt_d;
            lineErr_q   <= lineErr_d;
            geomErr_q   <= geomErr_d;
            motionAcc_q <= motionAcc_d;
            motionCnt_q <= motionCnt_d;
            alarm_q     <= alarm_d;
            frameErr_q  <= frameErr_d;
            frameCnt_q  <= frameCnt_d;
            refSel_q    <= refSel_d;
            overrun_q   <= overrun_d;
            frameDone_q <= frameDone_d;
            busy_q      <= busy_d;
        end
    end

    assign diff_threshold = actThr_q;
    assign erode_bypass   = actBypE_q;
    assign dilate_bypass  = actBypD_q;
    assign ref_sel        = refSel_q;
    assign busy           = busy_q;
    assign frame_done     = frameDone_q;
    assign frame_cnt      = frameCnt_q;
    assign motion_cnt     = motionCnt_q;
    assign motion_alarm   = alarm_q;
    assign frame_err      = frameErr_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_motion_frame_ctrl.sv
// Bench for motion_frame_ctrl: plays whole frames (output stream = input stream
// delayed by a fixed pipeline latency) and checks against a frame-level model.
module tb_motion_frame_ctrl;
    localparam int          HD      = 16;
    localparam int          VD      = 12;
    localparam int          LAT     = 8;
    localparam int          V0      = 2;
    localparam logic [7:0]  THR_DEF = 8'd80;
    localparam logic [18:0] ALM_DEF = 19'd50;

    logic        clk = 1'b0;
    logic        sys_rst, cfg_enable, cfg_wr_en;
    logic [7:0]  cfg_threshold;
    logic [18:0] cfg_alarm_level;
    logic        cfg_bypass_erode, cfg_bypass_dilate;
    logic        per_frame_vsync, per_frame_href, per_frame_clken;
    logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
    logic [7:0]  diff_threshold;
    logic        erode_bypass, dilate_bypass, ref_sel, busy, frame_done;
    logic [15:0] frame_cnt;
    logic [18:0] motion_cnt;
    logic        motion_alarm, frame_err, overrun;

    always #5 clk = ~clk;

    motion_frame_ctrl #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .DIFF_THR_DEF(THR_DEF), .ALARM_DEF(ALM_DEF)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .cfg_enable(cfg_enable), .cfg_wr_en(cfg_wr_en),
        .cfg_threshold(cfg_threshold), .cfg_alarm_level(cfg_alarm_level),
        .cfg_bypass_erode(cfg_bypass_erode), .cfg_bypass_dilate(cfg_bypass_dilate),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .post_frame_vsync(post_frame_vsync),
        .post_frame_href(post_frame_href), .post_frame_clken(post_frame_clken),
        .post_img_Bit(post_img_Bit), .diff_threshold(diff_threshold),
        .erode_bypass(erode_bypass), .dilate_bypass(dilate_bypass), .ref_sel(ref_sel),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .motion_cnt(motion_cnt), .motion_alarm(motion_alarm), .frame_err(frame_err),
        .overrun(overrun)
    );

    typedef struct {
        string      name;
        int         nLines;
        int         badLine;
        int         badLen;
        int         density;
        int         wrAt;
        logic [7:0] wrThr;
        int         almRel;
        logic       wrBe;
        logic       wrBd;
        logic       dropEn;
        logic       enable;
        logic       ovr;
        logic       rstDrain;
        logic       expErr;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;

    // Frame-level reference: pending/active config sets and reported results.
    logic [7:0]  pThr, aThr;
    logic [18:0] pAlm, aAlm;
    logic        pBe, pBd, aBe, aBd;
    int          mFrames;
    logic        mRef, mOvr, mEn;
    logic [18:0] mMotion;
    logic        mAlarm, mErr;

    logic qVs[$], qHref[$], qClk[$], qBit[$];
    int   fallIdx, frameMotion;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        pThr = THR_DEF; aThr = THR_DEF; pAlm = ALM_DEF; aAlm = ALM_DEF;
        pBe = 1'b0; pBd = 1'b0; aBe = 1'b0; aBd = 1'b0;
        mFrames = 0; mRef = 1'b0; mOvr = 1'b0;
        mMotion = '0; mAlarm = 1'b0; mErr = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_thr"}, 32'(diff_threshold), 32'(THR_DEF));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        checkOutput({tag, "_ref"}, 32'(ref_sel), 32'd0);
        checkOutput({tag, "_motion"}, 32'(motion_cnt), 32'd0);
        checkOutput({tag, "_alarm"}, 32'(motion_alarm), 32'd0);
        checkOutput({tag, "_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_ovr"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_byp"}, 32'({erode_bypass, dilate_bypass}), 32'd0);
    endtask

    function automatic logic rndBit(input int density);
        return ($urandom_range(0, 99) < density);
    endfunction

    task automatic pushCyc(input logic vs, input logic hr, input logic ck, input logic bt);
        qVs.push_back(vs); qHref.push_back(hr); qClk.push_back(ck); qBit.push_back(bt);
        if (hr && ck && bt) frameMotion++;
    endtask

    task automatic buildFrame(input int nLines, input int badLine, input int badLen, input int density);
        int n, cnt;
        logic ck;
        qVs.delete(); qHref.delete(); qClk.delete(); qBit.delete();
        frameMotion = 0;
        pushCyc(0, 0, 0, 0); pushCyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) pushCyc(1, 0, 0, rndBit(density));
        for (int l = 0; l < nLines; l++) begin
            n = (l == badLine) ? badLen : HD;
            cnt = 0;
            pushCyc(1, 0, 0, rndBit(density)); pushCyc(1, 0, 0, rndBit(density));
            while (cnt < n) begin
                ck = ($urandom_range(0, 3) != 0);
                pushCyc(1, 1, ck, rndBit(density));
                if (ck) cnt++;
            end
        end
        pushCyc(1, 0, 0, 0); pushCyc(1, 0, 0, 0);
        fallIdx = qVs.size();
        pushCyc(0, 0, 0, 0); pushCyc(0, 0, 0, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int          len, total, c0, doneCnt, expDone;
        logic [18:0] wrAlm;
        logic        acc, rstSeen;
        buildFrame(v.nLines, v.badLine, v.badLen, v.density);
        wrAlm   = 19'(frameMotion + v.almRel);
        len     = qVs.size();
        total   = len + LAT + 6;
        c0      = fallIdx + LAT;
        doneCnt = 0;
        rstSeen = 1'b0;
        mEn     = v.enable;
        acc     = v.enable;
        for (int c = 0; c < total; c++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) doneCnt++;
            if (c == V0) checkOutput({v.name, "_thrBeforeLoad"}, 32'(diff_threshold), 32'(aThr));
            if (c == V0 + 1) begin
                if (acc) begin aThr = pThr; aAlm = pAlm; aBe = pBe; aBd = pBd; end
                checkOutput({v.name, "_thrLoad"}, 32'(diff_threshold), 32'(aThr));
                checkOutput({v.name, "_bypLoad"}, 32'({erode_bypass, dilate_bypass}), 32'({aBe, aBd}));
                checkOutput({v.name, "_busyPre"}, 32'(busy), 32'd0);
            end
            if (c == V0 + 2) checkOutput({v.name, "_busyRise"}, 32'(busy), 32'(acc));
            if (v.rstDrain && c == fallIdx + 4) begin
                rstSeen = 1'b1;
                modelReset();
                checkResetState({v.name, "_rst"});
            end
            if (acc && !rstSeen && c == c0 + 1) begin
                checkOutput({v.name, "_busyHold"}, 32'(busy), 32'd1);
                checkOutput({v.name, "_doneEarly"}, 32'(frame_done), 32'd0);
            end
            if (acc && !rstSeen && c == c0 + 2) begin
                mFrames++; mRef = ~mRef;
                mMotion = 19'(frameMotion); mAlarm = (mMotion >= aAlm); mErr = v.expErr;
                checkOutput({v.name, "_done"}, 32'(frame_done), 32'd1);
                checkOutput({v.name, "_busyFall"}, 32'(busy), 32'd0);
                checkOutput({v.name, "_motion"}, 32'(motion_cnt), 32'(mMotion));
                checkOutput({v.name, "_alarm"}, 32'(motion_alarm), 32'(mAlarm));
                checkOutput({v.name, "_err"}, 32'(frame_err), 32'(mErr));
                checkOutput({v.name, "_fcnt"}, 32'(frame_cnt), 32'(mFrames));
                checkOutput({v.name, "_ref"}, 32'(ref_sel), 32'(mRef));
            end
            if (c == total - 1) checkOutput({v.name, "_thrEnd"}, 32'(diff_threshold), 32'(aThr));

            sys_rst    = v.rstDrain && (c == fallIdx + 3);
            cfg_wr_en  = (c == v.wrAt);
            if (c == 0) cfg_enable = v.enable;
            if (v.dropEn && c == fallIdx - 10) begin cfg_enable = 1'b0; mEn = 1'b0; end
            if (cfg_wr_en) begin
                cfg_threshold = v.wrThr; cfg_alarm_level = wrAlm;
                cfg_bypass_erode = v.wrBe; cfg_bypass_dilate = v.wrBd;
                pThr = v.wrThr; pAlm = wrAlm; pBe = v.wrBe; pBd = v.wrBd; mOvr = 1'b0;
            end else begin
                cfg_threshold = 8'($urandom); cfg_alarm_level = 19'($urandom);
                cfg_bypass_erode = 1'($urandom); cfg_bypass_dilate = 1'($urandom);
            end
            per_frame_vsync = (c < len) ? qVs[c] : 1'b0;
            per_frame_href  = (c < len) ? qHref[c] : 1'b0;
            per_frame_clken = (c < len) ? qClk[c] : 1'b0;
            if (v.ovr && c == fallIdx + 2) begin
                per_frame_vsync = 1'b1;
                if (acc) mOvr = 1'b1;
            end
            post_frame_vsync = (c >= LAT && c - LAT < len) ? qVs[c - LAT] : 1'b0;
            post_frame_href  = (c >= LAT && c - LAT < len) ? qHref[c - LAT] : 1'b0;
            post_frame_clken = (c >= LAT && c - LAT < len) ? qClk[c - LAT] : 1'b0;
            post_img_Bit     = (c >= LAT && c - LAT < len) ? qBit[c - LAT] : 1'b0;
        end
        expDone = (acc && !v.rstDrain) ? 1 : 0;
        checkOutput({v.name, "_doneCount"}, 32'(doneCnt), 32'(expDone));
        checkOutput({v.name, "_ovr"}, 32'(overrun), 32'(mOvr));
        checkOutput({v.name, "_fcntEnd"}, 32'(frame_cnt), 32'(mFrames));
    endtask

    vec_t tbl[17];

    initial begin
        vec_t rv;
        tbl[0]  = '{"clean",        VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{"midWrite",     VD, -1, 0,      50, 100, 8'd40, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{"thrApplied",   VD, -1, 0,      30, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{"shortLine",    VD, 10, HD - 1, 50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{"cleanAfter",   VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{"fewLines",     VD - 1, -1, 0,  50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{"longLine",     VD, 0, HD + 1,  50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{"wrSameCycle",  VD, -1, 0,      40, V0,  8'd33, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{"alarmAbove",   VD, -1, 0,      40, 0,   8'd20, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{"overrun",      VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{"rstDrain",     VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{"afterReset",   VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{"overrun2",     VD, -1, 0,      20, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{"clearOvr",     VD, -1, 0,      50, 100, 8'd99, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{"dropEnable",   VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{"ignored",      VD, -1, 0,      50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{"reEnable",     VD, 3, HD - 2,  50, -1,  8'd0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        sys_rst = 1'b1; cfg_enable = 1'b0; cfg_wr_en = 1'b0;
        cfg_threshold = '0; cfg_alarm_level = '0; cfg_bypass_erode = 1'b0; cfg_bypass_dilate = 1'b0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
        post_frame_vsync = 1'b0; post_frame_href = 1'b0; post_frame_clken = 1'b0; post_img_Bit = 1'b0;
        modelReset();
        mEn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        checkResetState("reset");

        for (int i = 0; i < 17; i++) applyStimulus(tbl[i]);

        for (int r = 0; r < 8; r++) begin
            rv.name     = $sformatf("rand%0d", r);
            rv.nLines   = ($urandom_range(0, 4) == 0) ? VD + 1 : VD;
            rv.badLine  = $urandom_range(0, 1) ? int'($urandom_range(0, VD - 1)) : -1;
            rv.badLen   = $urandom_range(0, 1) ? HD + 1 : HD - 1;
            rv.density  = int'($urandom_range(10, 90));
            case ($urandom_range(0, 4))
                0:       rv.wrAt = -1;
                1:       rv.wrAt = 1;
                2:       rv.wrAt = V0;
                3:       rv.wrAt = V0 + 1;
                default: rv.wrAt = 80;
            endcase
            rv.wrThr    = 8'($urandom);
            rv.almRel   = int'($urandom_range(0, 4)) - 2;
            rv.wrBe     = 1'($urandom);
            rv.wrBd     = 1'($urandom);
            rv.dropEn   = 1'b0;
            rv.enable   = 1'b1;
            rv.ovr      = ($urandom_range(0, 3) == 0);
            rv.rstDrain = 1'b0;
            rv.expErr   = (rv.badLine >= 0) || (rv.nLines != VD);
            applyStimulus(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
